instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_encoder_pkg.sv | 39 +++
 rtl/instr_encoder_pack.sv | 30 +++
 rtl/instr_encoder.sv | 130 +++++++++++++
 3 files changed

// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder and the decode-side control unit:
// instruction class codes, the six primary opcodes, and the encoder FSM states.
package instr_encoder_pkg;

  // Instruction class presented on in_class
  typedef enum logic [2:0] {
    CLS_R       = 3'd0,
    CLS_LW      = 3'd1,
    CLS_SW      = 3'd2,
    CLS_BEQ     = 3'd3,
    CLS_XORI    = 3'd4,
    CLS_J       = 3'd5,
    CLS_END     = 3'd6,
    CLS_ILLEGAL = 3'd7
  } in_class_e;

  // Primary opcodes (instruction bits 31:26)
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_XORI = 6'b001110;
  localparam logic [5:0] OP_J    = 6'b000010;

  // Load-session states
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // I-type layout shared by LW, SW, BEQ and XORI
  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// instr_pack: purely combinational packer turning decoded fields into a 32-bit word.
// END and illegal classes pack to an all-zero word (NOP).
import instr_encoder_pkg::*;

module instr_pack (
  input  logic [2:0]  in_class,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic [31:0] word
);

  // Select the field layout for the instruction class
  always_comb begin
    word = '0;
    case (in_class_e'(in_class))
      CLS_R:    word = {OP_R, rs, rt, rd, 5'b00000, funct};
      CLS_LW:   word = i_type(OP_LW, rs, rt, imm);
      CLS_SW:   word = i_type(OP_SW, rs, rt, imm);
      CLS_BEQ:  word = i_type(OP_BEQ, rs, rt, imm);
      CLS_XORI: word = i_type(OP_XORI, rs, rt, imm);
      CLS_J:    word = {OP_J, target};
      default:  word = '0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: accepts instruction fields, encodes them and streams the words
// into instruction memory through a one-entry output buffer with incrementing
// byte addresses.
// Build option: define INSTR_ENC_TRAP_EN to make class 7 set the sticky err flag
// and end the session instead of emitting a NOP word.
import instr_encoder_pkg::*;

module instr_encoder #(
  parameter int          ADDR_W    = 10,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_class,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [5:0]        in_funct,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  output logic [ADDR_W-2:0] word_count,
  output logic              done,
  output logic              err
);

  localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(4);
  localparam logic [ADDR_W-2:0] COUNT_STEP = (ADDR_W-1)'(1);

  state_e      state;
  state_e      state_next;
  logic [31:0] packed_word;
  logic        accept;
  logic        take;
  logic        is_end;
  logic        emit;
  logic        stop_load;
  logic        trap_hit;
  logic        restart;

  instr_pack u_pack (
    .in_class (in_class),
    .rs       (in_rs),
    .rt       (in_rt),
    .rd       (in_rd),
    .funct    (in_funct),
    .imm      (in_imm),
    .target   (in_target),
    .word     (packed_word)
  );

  // A new word may enter when the buffer is empty or is being emptied this cycle
  assign in_ready = (state == ST_LOAD) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign take     = out_valid && out_ready;
  assign is_end   = (in_class_e'(in_class) == CLS_END);
  assign restart  = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign done     = (state == ST_DONE);

`ifdef INSTR_ENC_TRAP_EN
  logic is_trap;
  assign is_trap   = (in_class_e'(in_class) == CLS_ILLEGAL);
  assign emit      = accept && !is_end && !is_trap;
  assign stop_load = accept && (is_end || is_trap);
  assign trap_hit  = accept && is_trap;
`else
  assign emit      = accept && !is_end;
  assign stop_load = accept && is_end;
  assign trap_hit  = 1'b0;
`endif

  // Session state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Session sequencing: load until END, then wait for the buffer to empty
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_next = ST_LOAD;
      ST_LOAD:          if (stop_load) state_next = ST_DRAIN;
      ST_DRAIN:         if (!out_valid || out_ready) state_next = ST_DONE;
      default:          state_next = ST_IDLE;
    endcase
  end

  // One-entry output buffer; a refill on the draining edge leaves no bubble
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_word  <= '0;
    end else if (emit) begin
      out_valid <= 1'b1;
      out_word  <= packed_word;
    end else if (take) begin
      out_valid <= 1'b0;
    end
  end

  // Write address and word counter advance on every completed memory write
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_addr   <= BASE;
      word_count <= '0;
    end else if (restart) begin
      out_addr   <= BASE;
      word_count <= '0;
    end else if (take) begin
      out_addr   <= out_addr + ADDR_STEP;
      word_count <= word_count + COUNT_STEP;
    end
  end

  // Sticky illegal-class flag, cleared when a new session starts
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        err <= 1'b0;
    else if (restart) err <= 1'b0;
    else if (trap_hit) err <= 1'b1;
  end

endmodule
